// File: rtl/vc_rx_pkg.sv
// rtl/vc_rx_pkg.sv - shared types and helpers for the VC receive demux
package vc_rx_pkg;

   localparam int FLIT_DATA_W = 32;

   typedef enum logic {IDLE, LOCKED} rx_state_e;

   typedef struct packed {
      logic                   head;
      logic                   tail;
      logic [FLIT_DATA_W-1:0] data;
   } flit_t;

   function automatic int num_vc(input int vc_addr_width);
      return 1 << vc_addr_width;
   endfunction

endpackage

// File: rtl/vc_rx_fifo.sv
// rtl/vc_rx_fifo.sv - per-VC flit FIFO; a push while full is dropped even if popped that cycle
module vc_rx_fifo
   import vc_rx_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  push_i,
   input  logic  pop_i,
   input  flit_t flit_i,
   output flit_t front_o,
   output logic  empty_o,
   output logic  full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   flit_t         mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_COUNT);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign front_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= flit_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/vc_rx_demux.sv
// rtl/vc_rx_demux.sv - per-VC buffering, credit return and packet-atomic round-robin merge
// Optional sticky credit-violation flags: VC_RX_OVF_CHECK_EN.
module vc_rx_demux
   import vc_rx_pkg::*;
#(
   parameter int WIDTH_DATA    = FLIT_DATA_W,
   parameter int VC_ADDR_WIDTH = 2,
   parameter int DEPTH         = 4,
   localparam int NUM_VC       = num_vc(VC_ADDR_WIDTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     valid_in,
   input  logic                     head_in,
   input  logic                     tail_in,
   input  logic [VC_ADDR_WIDTH-1:0] vc_in,
   input  logic [WIDTH_DATA-1:0]    data_in,
   output logic [NUM_VC-1:0]        credit_out,
   output logic                     valid_out,
   output logic                     head_out,
   output logic                     tail_out,
   output logic [VC_ADDR_WIDTH-1:0] vc_out,
   output logic [WIDTH_DATA-1:0]    data_out,
   input  logic                     ready_in,
   output logic [NUM_VC-1:0]        overflow_out
);

   flit_t                     flit_in;
   flit_t                     front [NUM_VC];
   flit_t                     cur;
   logic [NUM_VC-1:0]         empty;
   logic [NUM_VC-1:0]         full;
   logic [NUM_VC-1:0]         push_vc;
   logic [NUM_VC-1:0]         pop_vc;
   logic [NUM_VC-1:0]         credit_q;
   rx_state_e                 state_q;
   logic [VC_ADDR_WIDTH-1:0]  rr_q;
   logic [VC_ADDR_WIDTH-1:0]  grant_q;
   logic [VC_ADDR_WIDTH-1:0]  pick_vc;
   logic [VC_ADDR_WIDTH-1:0]  arb_idx;
   logic                      pick_ok;
   logic                      xfer;

   assign flit_in.head = head_in;
   assign flit_in.tail = tail_in;
   assign flit_in.data = data_in;

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      assign push_vc[v] = valid_in && (vc_in == VC_ADDR_WIDTH'(v));
      assign pop_vc[v]  = xfer && (grant_q == VC_ADDR_WIDTH'(v));

      vc_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .push_i  (push_vc[v]),
         .pop_i   (pop_vc[v]),
         .flit_i  (flit_in),
         .front_o (front[v]),
         .empty_o (empty[v]),
         .full_o  (full[v])
      );
   end

   // Output is only meaningful while locked; gating keeps idle outputs at zero.
   assign cur        = front[grant_q];
   assign valid_out  = (state_q == LOCKED) && !empty[grant_q];
   assign xfer       = valid_out && ready_in;
   assign head_out   = valid_out && cur.head;
   assign tail_out   = valid_out && cur.tail;
   assign vc_out     = valid_out ? grant_q : '0;
   assign data_out   = valid_out ? cur.data : '0;
   assign credit_out = credit_q;

   // Scan downward so the candidate closest to the RR pointer wins.
   always_comb begin
      pick_vc = '0;
      pick_ok = 1'b0;
      arb_idx = '0;
      for (int i = NUM_VC - 1; i >= 0; i--) begin
         arb_idx = rr_q + VC_ADDR_WIDTH'(i);
         if (!empty[arb_idx] && front[arb_idx].head) begin
            pick_vc = arb_idx;
            pick_ok = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rr_q    <= '0;
         grant_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_ok) begin
                  grant_q <= pick_vc;
                  state_q <= LOCKED;
               end
            end
            LOCKED: begin
               if (xfer && cur.tail) begin
                  state_q <= IDLE;
                  rr_q    <= grant_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) credit_q <= '0;
      else        credit_q <= pop_vc;
   end

`ifdef VC_RX_OVF_CHECK_EN
   logic [NUM_VC-1:0] ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= '0;
      else        ovf_q <= ovf_q | (push_vc & full);
   end

   assign overflow_out = ovf_q;
`else
   assign overflow_out = '0;
`endif

endmodule

// File: tb/tb_vc_rx_demux.sv
// tb/tb_vc_rx_demux.sv - scoreboard bench for vc_rx_demux
module tb_vc_rx_demux;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_in = 1'b0;
   logic        head_in = 1'b0;
   logic        tail_in = 1'b0;
   logic [1:0]  vc_in = '0;
   logic [31:0] data_in = '0;
   logic [3:0]  credit_out;
   logic        valid_out;
   logic        head_out;
   logic        tail_out;
   logic [1:0]  vc_out;
   logic [31:0] data_out;
   logic        ready_in = 1'b0;
   logic [3:0]  overflow_out;

`ifdef VC_RX_OVF_CHECK_EN
   localparam logic [3:0] OVF_EXP = 4'b0100;
`else
   localparam logic [3:0] OVF_EXP = 4'b0000;
`endif

   typedef struct {
      logic        head;
      logic        tail;
      logic [31:0] data;
   } exp_t;

   exp_t sb [4][$];
   int   n_checks = 0;
   int   n_pass = 0;

   vc_rx_demux dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .valid_in     (valid_in),
      .head_in      (head_in),
      .tail_in      (tail_in),
      .vc_in        (vc_in),
      .data_in      (data_in),
      .credit_out   (credit_out),
      .valid_out    (valid_out),
      .head_out     (head_out),
      .tail_out     (tail_out),
      .vc_out       (vc_out),
      .data_out     (data_out),
      .ready_in     (ready_in),
      .overflow_out (overflow_out)
   );

   always #5 clk = ~clk;

   // Drives one flit for one clock; call at posedge+1, returns at posedge+1.
   task automatic send(input logic [1:0] vc, input logic h, input logic t,
                       input logic [31:0] d, input bit accepted);
      valid_in = 1'b1;
      vc_in    = vc;
      head_in  = h;
      tail_in  = t;
      data_in  = d;
      if (accepted) sb[vc].push_back('{head: h, tail: t, data: d});
      @(posedge clk); #1;
      valid_in = 1'b0;
   endtask

   task automatic test_reset;
      rst_n    = 1'b0;
      ready_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out); else n_pass++;
      n_checks++; if (credit_out !== 4'b0) $display("FAIL reset_credit: got %b want 0000", credit_out); else n_pass++;
      n_checks++; if (overflow_out !== 4'b0) $display("FAIL reset_overflow: got %b want 0000", overflow_out); else n_pass++;
      n_checks++;
      if ({head_out, tail_out, vc_out, data_out} !== 36'h0)
         $display("FAIL reset_outputs: got h%b t%b vc%0d d%h want all zero", head_out, tail_out, vc_out, data_out);
      else n_pass++;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      ready_in = 1'b1;
      send(2'd1, 1'b1, 1'b1, 32'hA5, 1'b0);
      @(negedge clk);
      n_checks++; if (valid_out !== 1'b0) $display("FAIL single_no_bypass: got valid %b want 0", valid_out); else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({valid_out, head_out, tail_out, vc_out, data_out} !== {3'b111, 2'd1, 32'hA5})
         $display("FAIL single_flit: got v%b h%b t%b vc%0d d%h want v1 h1 t1 vc1 d000000a5",
                  valid_out, head_out, tail_out, vc_out, data_out);
      else n_pass++;
      @(negedge clk);
      n_checks++; if (credit_out !== 4'b0010) $display("FAIL single_credit: got %b want 0010", credit_out); else n_pass++;
      @(negedge clk);
      n_checks++; if (credit_out !== 4'b0000) $display("FAIL single_credit_pulse: got %b want 0000", credit_out); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_interleave;
      logic [3:0] exp_cr;
      logic [1:0] cur_vc;
      exp_t       e;
      int         got;
      exp_cr   = '0;
      cur_vc   = '0;
      got      = 0;
      ready_in = 1'b1;
      fork
         begin
            send(2'd0, 1'b1, 1'b0, 32'h10, 1'b1);
            send(2'd1, 1'b1, 1'b0, 32'h20, 1'b1);
            send(2'd0, 1'b0, 1'b0, 32'h11, 1'b1);
            send(2'd1, 1'b0, 1'b0, 32'h21, 1'b1);
            send(2'd0, 1'b0, 1'b1, 32'h12, 1'b1);
            send(2'd1, 1'b0, 1'b1, 32'h22, 1'b1);
         end
         begin
            for (int c = 0; c < 25; c++) begin
               @(negedge clk);
               n_checks++; if (credit_out !== exp_cr) $display("FAIL il_credit: got %b want %b", credit_out, exp_cr); else n_pass++;
               exp_cr = '0;
               if (valid_out && ready_in) begin
                  n_checks++;
                  if (sb[vc_out].size() == 0) begin
                     $display("FAIL il_unexpected: flit on vc%0d d%h with none expected", vc_out, data_out);
                  end else begin
                     e = sb[vc_out].pop_front();
                     if ({head_out, tail_out, data_out} !== {e.head, e.tail, e.data})
                        $display("FAIL il_flit: got h%b t%b d%h want h%b t%b d%h",
                                 head_out, tail_out, data_out, e.head, e.tail, e.data);
                     else n_pass++;
                  end
                  if (got == 0) begin
                     n_checks++; if (vc_out !== 2'd0) $display("FAIL il_first_vc: got %0d want 0", vc_out); else n_pass++;
                  end
                  if (head_out) cur_vc = vc_out;
                  else begin
                     n_checks++; if (vc_out !== cur_vc) $display("FAIL il_atomic: got vc%0d want vc%0d", vc_out, cur_vc); else n_pass++;
                  end
                  exp_cr = 4'b0001 << vc_out;
                  got++;
               end
            end
         end
      join
      n_checks++; if (got !== 6) $display("FAIL il_count: got %0d flits want 6", got); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_overflow;
      logic [31:0] d [5] = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h2FF};
      logic        h [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic        t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [3:0]  exp_cr;
      exp_t        e;
      int          got;
      ready_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(2'd2, h[i], t[i], d[i], i < 4);
         n_checks++; if (credit_out !== 4'b0) $display("FAIL ovf_credit_%0d: got %b want 0000", i, credit_out); else n_pass++;
      end
      n_checks++; if (overflow_out !== OVF_EXP) $display("FAIL ovf_flag: got %b want %b", overflow_out, OVF_EXP); else n_pass++;
      n_checks++;
      if ({valid_out, vc_out, data_out} !== {1'b1, 2'd2, 32'h200})
         $display("FAIL ovf_front: got v%b vc%0d d%h want v1 vc2 d00000200", valid_out, vc_out, data_out);
      else n_pass++;
      exp_cr   = '0;
      got      = 0;
      ready_in = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         n_checks++; if (credit_out !== exp_cr) $display("FAIL ovf_drain_credit: got %b want %b", credit_out, exp_cr); else n_pass++;
         exp_cr = '0;
         if (valid_out && ready_in) begin
            n_checks++;
            if (sb[vc_out].size() == 0) begin
               $display("FAIL ovf_unexpected: flit on vc%0d d%h with none expected", vc_out, data_out);
            end else begin
               e = sb[vc_out].pop_front();
               if ({head_out, tail_out, data_out} !== {e.head, e.tail, e.data})
                  $display("FAIL ovf_drain_flit: got h%b t%b d%h want h%b t%b d%h",
                           head_out, tail_out, data_out, e.head, e.tail, e.data);
               else n_pass++;
            end
            exp_cr = 4'b0001 << vc_out;
            got++;
         end
      end
      n_checks++; if (got !== 4) $display("FAIL ovf_drain_count: got %0d flits want 4", got); else n_pass++;
      n_checks++; if (overflow_out !== OVF_EXP) $display("FAIL ovf_sticky: got %b want %b", overflow_out, OVF_EXP); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_stall;
      ready_in = 1'b0;
      send(2'd1, 1'b1, 1'b0, 32'h100, 1'b0);
      send(2'd1, 1'b0, 1'b0, 32'h101, 1'b0);
      send(2'd1, 1'b0, 1'b1, 32'h102, 1'b0);
      for (int c = 0; c < 10 && !valid_out; c++) @(negedge clk);
      n_checks++;
      if ({valid_out, head_out, vc_out, data_out} !== {2'b11, 2'd1, 32'h100})
         $display("FAIL stall_first: got v%b h%b vc%0d d%h want v1 h1 vc1 d00000100", valid_out, head_out, vc_out, data_out);
      else n_pass++;
      @(posedge clk); #1 ready_in = 1'b1;
      @(posedge clk); #1 ready_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if ({valid_out, head_out, tail_out, vc_out, data_out} !== {3'b100, 2'd1, 32'h101})
            $display("FAIL stall_hold_%0d: got v%b h%b t%b vc%0d d%h want v1 h0 t0 vc1 d00000101",
                     k, valid_out, head_out, tail_out, vc_out, data_out);
         else n_pass++;
         n_checks++;
         if (credit_out !== ((k == 0) ? 4'b0010 : 4'b0000))
            $display("FAIL stall_credit_%0d: got %b want %b", k, credit_out, (k == 0) ? 4'b0010 : 4'b0000);
         else n_pass++;
      end
      @(posedge clk); #1 ready_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({valid_out, tail_out, data_out, credit_out} !== {2'b11, 32'h102, 4'b0010})
         $display("FAIL stall_resume: got v%b t%b d%h cr%b want v1 t1 d00000102 cr0010", valid_out, tail_out, data_out, credit_out);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({valid_out, credit_out} !== {1'b0, 4'b0010})
         $display("FAIL stall_end: got v%b cr%b want v0 cr0010", valid_out, credit_out);
      else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      ready_in = 1'b1;
      send(2'd0, 1'b1, 1'b0, 32'h500, 1'b0);
      send(2'd0, 1'b0, 1'b0, 32'h501, 1'b0);
      n_checks++; if (valid_out !== 1'b1) $display("FAIL rmid_pre: got valid %b want 1", valid_out); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({valid_out, credit_out, vc_out, data_out} !== 39'h0)
         $display("FAIL rmid_async: got v%b cr%b vc%0d d%h want all zero", valid_out, credit_out, vc_out, data_out);
      else n_pass++;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      send(2'd3, 1'b1, 1'b1, 32'h3C, 1'b0);
      for (int c = 0; c < 10 && !valid_out; c++) @(negedge clk);
      n_checks++;
      if ({valid_out, head_out, tail_out, vc_out, data_out} !== {3'b111, 2'd3, 32'h3C})
         $display("FAIL rmid_new: got v%b h%b t%b vc%0d d%h want v1 h1 t1 vc3 d0000003c",
                  valid_out, head_out, tail_out, vc_out, data_out);
      else n_pass++;
      @(negedge clk);
      n_checks++; if (credit_out !== 4'b1000) $display("FAIL rmid_credit: got %b want 1000", credit_out); else n_pass++;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++; if (valid_out !== 1'b0) $display("FAIL rmid_discard_%0d: got valid %b want 0", c, valid_out); else n_pass++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      logic [1:0] exp_vc [4] = '{2'd0, 2'd3, 2'd0, 2'd3};
      logic [3:0] exp_cs [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
      logic [1:0] vcs [$];
      logic [3:0] crs [$];
      exp_t       e;
      ready_in = 1'b1;
      fork
         begin
            send(2'd0, 1'b1, 1'b1, 32'h60, 1'b1);
            send(2'd3, 1'b1, 1'b1, 32'h63, 1'b1);
            send(2'd0, 1'b1, 1'b1, 32'h64, 1'b1);
            send(2'd3, 1'b1, 1'b1, 32'h67, 1'b1);
         end
         begin
            for (int c = 0; c < 20; c++) begin
               @(negedge clk);
               if (credit_out !== 4'b0) crs.push_back(credit_out);
               if (valid_out && ready_in) begin
                  vcs.push_back(vc_out);
                  n_checks++;
                  if (sb[vc_out].size() == 0) begin
                     $display("FAIL b2b_unexpected: flit on vc%0d d%h with none expected", vc_out, data_out);
                  end else begin
                     e = sb[vc_out].pop_front();
                     if ({head_out, tail_out, data_out} !== {e.head, e.tail, e.data})
                        $display("FAIL b2b_flit: got h%b t%b d%h want h%b t%b d%h",
                                 head_out, tail_out, data_out, e.head, e.tail, e.data);
                     else n_pass++;
                  end
               end
            end
         end
      join
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= vcs.size()) $display("FAIL b2b_order_%0d: got no flit want vc%0d", i, exp_vc[i]);
         else if (vcs[i] !== exp_vc[i]) $display("FAIL b2b_order_%0d: got vc%0d want vc%0d", i, vcs[i], exp_vc[i]);
         else n_pass++;
         n_checks++;
         if (i >= crs.size()) $display("FAIL b2b_credit_%0d: got no pulse want %b", i, exp_cs[i]);
         else if (crs[i] !== exp_cs[i]) $display("FAIL b2b_credit_%0d: got %b want %b", i, crs[i], exp_cs[i]);
         else n_pass++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_interleave();
      test_overflow();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
